pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/pipe_wdog.sv | 27 ++
 rtl/pipe_ctrl.sv | 65 ++++++
 tb/tb_pipe_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control defines (stall vectors, exception codes, FSM encoding)
package pipe_ctrl_pkg;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
   localparam logic [5:0]  STALL_NONE  = 6'b000000;
   localparam logic [5:0]  STALL_ID    = 6'b000111;
   localparam logic [5:0]  STALL_EX    = 6'b001111;
   localparam logic [5:0]  STALL_MEM   = 6'b011111;
   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} pc_state_e;
endpackage

// File: rtl/pipe_wdog.sv
// pipe_wdog: counts consecutive stalled cycles and raises a sticky timeout at WD_LIMIT
// Ports: clk, rst (sync, active-high), stalled_i (stall vector non-zero), timeout_o (sticky flag)
module pipe_wdog #(
   parameter int unsigned WD_LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic stalled_i,
   output logic timeout_o
);
   logic [31:0] run_q, run_d;
   logic        to_q, to_d;
   always_comb begin
      run_d = stalled_i ? ((run_q == 32'(WD_LIMIT)) ? run_q : run_q + 32'd1) : 32'd0;
      to_d  = to_q | (run_d == 32'(WD_LIMIT));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 32'd0;
         to_q  <= 1'b0;
      end else begin
         run_q <= run_d;
         to_q  <= to_d;
      end
   end
   assign timeout_o = to_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with exception redirect and stall statistics
// Ports: clk, rst (sync, active-high); stallreq_id/ex/mem stall requests; excepttype_i, epc_i from MEM/CP0;
//        stall[5:0] freeze vector (combinational), flush + new_pc (registered redirect),
//        stall_timeout (sticky watchdog, only with PIPE_CTRL_WATCHDOG_EN), stall_cycles (saturating)
// Build option: define PIPE_CTRL_WATCHDOG_EN to include the consecutive-stall watchdog.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0]  EXC_VECTOR = 32'h0000_0020,
   parameter int unsigned  WD_LIMIT   = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles
);
   pc_state_e   state_q, state_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [31:0] cyc_q, cyc_d;
   logic        any_req, exc_take;
   always_comb begin
      any_req  = stallreq_id | stallreq_ex | stallreq_mem;
      // exceptions are only accepted outside FLUSH, so a second one during FLUSH is dropped
      exc_take = (state_q != FLUSH) && (excepttype_i != ZeroWord);
      stall    = (state_q == FLUSH || exc_take) ? STALL_NONE :
                 stallreq_mem ? STALL_MEM :
                 stallreq_ex  ? STALL_EX  :
                 stallreq_id  ? STALL_ID  : STALL_NONE;
      state_d  = exc_take ? FLUSH : any_req ? STALL : RUN;
      new_pc_d = !exc_take ? ZeroWord : (excepttype_i == EXC_ERET) ? epc_i : EXC_VECTOR;
      cyc_d    = cyc_q + {31'd0, (stall != STALL_NONE) && (cyc_q != 32'hFFFF_FFFF)};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         new_pc_q <= ZeroWord;
         cyc_q    <= ZeroWord;
      end else begin
         state_q  <= state_d;
         new_pc_q <= new_pc_d;
         cyc_q    <= cyc_d;
      end
   end
   assign flush        = (state_q == FLUSH);
   assign new_pc       = new_pc_q;
   assign stall_cycles = cyc_q;
`ifdef PIPE_CTRL_WATCHDOG_EN
   pipe_wdog #(.WD_LIMIT(WD_LIMIT)) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .stalled_i (stall != STALL_NONE),
      .timeout_o (stall_timeout)
   );
`else
   assign stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst, stallreq_id, stallreq_ex, stallreq_mem;
   logic [31:0] excepttype_i, epc_i;
   logic [5:0]  stall;
   logic        flush, stall_timeout;
   logic [31:0] new_pc, stall_cycles;
   int checks = 0;
   int failures = 0;
`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam logic WD_ON = 1'b1;
`else
   localparam logic WD_ON = 1'b0;
`endif

   pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .WD_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem), .excepttype_i(excepttype_i), .epc_i(epc_i),
      .stall(stall), .flush(flush), .new_pc(new_pc), .stall_timeout(stall_timeout),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
      excepttype_i = 32'd0; epc_i = 32'd0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_new_pc", new_pc, 32'd0);
      check("rst_cycles", stall_cycles, 32'd0);
      check("rst_stall", {26'd0, stall}, 32'd0);
      check("rst_timeout", {31'd0, stall_timeout}, 32'd0);
      stallreq_ex = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("ex_stall", {26'd0, stall}, 32'h0f);
         tick();
      end
      stallreq_ex = 1'b0;
      #1 check("ex_idle_stall", {26'd0, stall}, 32'd0);
      check("ex_cycles", stall_cycles, 32'd3);
      stallreq_id = 1'b1; stallreq_mem = 1'b1;
      #1 check("id_mem_stall", {26'd0, stall}, 32'h1f);
      tick();
      stallreq_id = 1'b0; stallreq_mem = 1'b0;
      #1 check("id_mem_cycles", stall_cycles, 32'd4);
      tick();
      excepttype_i = 32'h8;
      #1 check("exc_same_stall", {26'd0, stall}, 32'd0);
      tick();
      excepttype_i = 32'h0;
      #1 check("exc_flush", {31'd0, flush}, 32'd1);
      check("exc_new_pc", new_pc, 32'h20);
      check("exc_flush_stall", {26'd0, stall}, 32'd0);
      tick();
      check("exc_flush_end", {31'd0, flush}, 32'd0);
      check("exc_new_pc_end", new_pc, 32'd0);
      excepttype_i = 32'he; epc_i = 32'h1234;
      tick();
      excepttype_i = 32'h0; epc_i = 32'h0;
      #1 check("eret_flush", {31'd0, flush}, 32'd1);
      check("eret_new_pc", new_pc, 32'h1234);
      tick();
      stallreq_mem = 1'b1; excepttype_i = 32'h8;
      #1 check("exc_mem_stall", {26'd0, stall}, 32'd0);
      tick();
      check("exc_mem_flush", {31'd0, flush}, 32'd1);
      check("exc_mem_flush_stall", {26'd0, stall}, 32'd0);
      tick();
      excepttype_i = 32'h0;
      #1 check("second_exc_no_flush", {31'd0, flush}, 32'd0);
      check("after_flush_stall", {26'd0, stall}, 32'h1f);
      check("after_flush_cycles", stall_cycles, 32'd4);
      tick();
      stallreq_mem = 1'b0;
      tick();
      stallreq_id = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("wd_before_limit", {31'd0, stall_timeout}, 32'd0);
      tick();
      check("wd_at_limit", {31'd0, stall_timeout}, {31'd0, WD_ON});
      stallreq_id = 1'b0;
      tick(); tick();
      check("wd_sticky", {31'd0, stall_timeout}, {31'd0, WD_ON});
      check("wd_cycles", stall_cycles, 32'd9);
      stallreq_mem = 1'b1; rst = 1'b1;
      #1 check("rst_comb_stall", {26'd0, stall}, 32'h1f);
      tick();
      check("rst_mid_cycles", stall_cycles, 32'd0);
      check("rst_mid_timeout", {31'd0, stall_timeout}, 32'd0);
      rst = 1'b0; stallreq_mem = 1'b0; excepttype_i = 32'h8;
      tick();
      check("pre_rst_flush", {31'd0, flush}, 32'd1);
      rst = 1'b1; excepttype_i = 32'h0;
      tick();
      check("rst_mid_flush", {31'd0, flush}, 32'd0);
      check("rst_mid_new_pc", new_pc, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
